// File: rtl/dispense_scheduler.sv
// Round-robin scheduler sharing one pump/valve between two dispenser panels.
// Times the pump per ml, handles per-panel cancel and forces a valve-switch gap after every job.
module dispense_scheduler #(
   parameter int CLOCKS_PER_ML = 5,
   parameter int MAX_ML        = 9999,
   parameter int AMOUNT_WIDTH  = 14,
   parameter int GAP_CYCLES    = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [1:0]              req_valid,
   input  logic [AMOUNT_WIDTH-1:0] req_amount_0,
   input  logic [AMOUNT_WIDTH-1:0] req_amount_1,
   input  logic [1:0]              cancel,
   output logic [1:0]              req_ready,
   output logic                    pump_on,
   output logic                    valve_sel,
   output logic [AMOUNT_WIDTH-1:0] dispensed_ml,
   output logic                    busy,
   output logic [1:0]              done,
   output logic [1:0]              aborted
);

   localparam int TICK_W = (CLOCKS_PER_ML > 1) ? $clog2(CLOCKS_PER_ML) : 1;
   localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [AMOUNT_WIDTH-1:0] MAX_C     = AMOUNT_WIDTH'(MAX_ML);
   localparam logic [TICK_W-1:0]       TICK_LAST = TICK_W'(CLOCKS_PER_ML - 1);
   localparam logic [GAP_W-1:0]        GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PUMP   = 2'd1,
      ST_FINISH = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    ptr_q, ptr_d;
   logic                    sel_q, sel_d;
   logic [AMOUNT_WIDTH-1:0] target_q, target_d;
   logic [AMOUNT_WIDTH-1:0] disp_q, disp_d;
   logic [TICK_W-1:0]       tick_q, tick_d;
   logic [GAP_W-1:0]        gap_q, gap_d;
   logic [1:0]              ready_q, ready_d;
   logic [1:0]              done_q, done_d;
   logic [1:0]              abort_q, abort_d;
   logic                    pump_q, pump_d;
   logic                    busy_q, busy_d;

   logic                    grant_s;
   logic [AMOUNT_WIDTH-1:0] amount_s;
   logic [AMOUNT_WIDTH-1:0] clamp_s;
   logic                    wrap_s;
   logic [AMOUNT_WIDTH-1:0] disp_inc_s;

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      sel_d      = sel_q;
      target_d   = target_q;
      disp_d     = disp_q;
      tick_d     = tick_q;
      gap_d      = gap_q;
      ready_d    = 2'b00;
      done_d     = 2'b00;
      abort_d    = 2'b00;
      grant_s    = ptr_q;
      amount_s   = req_amount_0;
      clamp_s    = req_amount_0;
      wrap_s     = (tick_q == TICK_LAST);
      disp_inc_s = disp_q + AMOUNT_WIDTH'(1);

      if (req_valid[ptr_q]) grant_s = ptr_q;
      else                  grant_s = ~ptr_q;

      if (grant_s) amount_s = req_amount_1;
      else         amount_s = req_amount_0;

      if (amount_s > MAX_C) clamp_s = MAX_C;
      else                  clamp_s = amount_s;

      case (state_q)
         ST_IDLE: begin
            if (req_valid != 2'b00) begin
               ready_d  = grant_s ? 2'b10 : 2'b01;
               sel_d    = grant_s;
               ptr_d    = ~grant_s;
               target_d = clamp_s;
               disp_d   = {AMOUNT_WIDTH{1'b0}};
               tick_d   = {TICK_W{1'b0}};
               if (clamp_s != {AMOUNT_WIDTH{1'b0}}) state_d = ST_PUMP;
               else                                 state_d = ST_FINISH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PUMP: begin
            if (wrap_s) begin
               tick_d = {TICK_W{1'b0}};
               disp_d = disp_inc_s;
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
            // Cancel outranks completion even on the final-ml tick.
            if (cancel[sel_q]) begin
               abort_d = sel_q ? 2'b10 : 2'b01;
               gap_d   = {GAP_W{1'b0}};
               state_d = ST_GAP;
            end else if (wrap_s && (disp_inc_s == target_q)) begin
               state_d = ST_FINISH;
            end else begin
               state_d = ST_PUMP;
            end
         end
         ST_FINISH: begin
            done_d  = sel_q ? 2'b10 : 2'b01;
            gap_d   = {GAP_W{1'b0}};
            state_d = ST_GAP;
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d   = gap_q + GAP_W'(1);
               state_d = ST_GAP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      pump_d = (state_d == ST_PUMP);
      busy_d = (state_d != ST_IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 1'b0;
         sel_q    <= 1'b0;
         target_q <= {AMOUNT_WIDTH{1'b0}};
         disp_q   <= {AMOUNT_WIDTH{1'b0}};
         tick_q   <= {TICK_W{1'b0}};
         gap_q    <= {GAP_W{1'b0}};
         ready_q  <= 2'b00;
         done_q   <= 2'b00;
         abort_q  <= 2'b00;
         pump_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         sel_q    <= sel_d;
         target_q <= target_d;
         disp_q   <= disp_d;
         tick_q   <= tick_d;
         gap_q    <= gap_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         abort_q  <= abort_d;
         pump_q   <= pump_d;
         busy_q   <= busy_d;
      end
   end

   assign req_ready    = ready_q;
   assign pump_on      = pump_q;
   assign valve_sel    = sel_q;
   assign dispensed_ml = disp_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign aborted      = abort_q;

endmodule

// File: tb/tb_dispense_scheduler.sv
// Scoreboard bench for dispense_scheduler: jobs are queued as they are requested and
// checked against what the DUT reports when it grants, pumps and finishes them.
module tb_dispense_scheduler;

   localparam int CPM = 2;
   localparam int GAP = 3;
   localparam int MAXML = 5;
   localparam int AW  = 14;

   logic          clock;
   logic          reset;
   logic [1:0]    req_valid;
   logic [AW-1:0] req_amount_0;
   logic [AW-1:0] req_amount_1;
   logic [1:0]    cancel;
   logic [1:0]    req_ready;
   logic          pump_on;
   logic          valve_sel;
   logic [AW-1:0] dispensed_ml;
   logic          busy;
   logic [1:0]    done;
   logic [1:0]    aborted;

   typedef struct {
      int panel;
      int kind;   // 0 = completes with done, 1 = ends with aborted
      int disp;
      int pump;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   closed   = 0;
   bit   active   = 1'b0;

   dispense_scheduler #(
      .CLOCKS_PER_ML (CPM),
      .MAX_ML        (MAXML),
      .AMOUNT_WIDTH  (AW),
      .GAP_CYCLES    (GAP)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_amount_0 (req_amount_0),
      .req_amount_1 (req_amount_1),
      .cancel       (cancel),
      .req_ready    (req_ready),
      .pump_on      (pump_on),
      .valve_sel    (valve_sel),
      .dispensed_ml (dispensed_ml),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input int obs, input int want);
      n_checks++;
      if (obs != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, want, $time);
      end
   endtask

   task automatic push_job(input int panel, input int kind, input int disp, input int pump);
      exp_t e;
      e.panel = panel;
      e.kind  = kind;
      e.disp  = disp;
      e.pump  = pump;
      exp_q.push_back(e);
   endtask

   task automatic wait_ready(output logic [1:0] got);
      bit seen = 1'b0;
      got = 2'b00;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clock); #1;
         if (req_ready != 2'b00) begin
            got  = req_ready;
            seen = 1'b1;
         end
      end
      if (!seen) check_val("ready_timeout", 0, 1);
   endtask

   task automatic wait_end();
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clock); #1;
         if ((done | aborted) != 2'b00) seen = 1'b1;
      end
      if (!seen) check_val("end_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int i = 0;
      while (busy && i < 200) begin
         @(posedge clock); #1;
         i++;
      end
      if (busy) check_val("idle_timeout", 0, 1);
   endtask

   task automatic run_single(input int panel, input int amount);
      logic [1:0] got;
      if (panel == 0) req_amount_0 = AW'(amount);
      else            req_amount_1 = AW'(amount);
      req_valid = (panel == 0) ? 2'b01 : 2'b10;
      wait_ready(got);
      req_valid = req_valid & ~got;
   endtask

   // Monitor: pops the expected job on each grant and settles it on done/aborted.
   initial begin : monitor
      int   pump_cnt;
      int   since;
      logic [1:0] prev_ready;
      pump_cnt   = 0;
      since      = 0;
      prev_ready = 2'b00;
      forever begin
         @(negedge clock);
         if (!reset) begin
            active     = 1'b0;
            prev_ready = 2'b00;
         end else begin
            if (req_ready != 2'b00) begin
               check_val("ready_pulse", prev_ready, 0);
               if (exp_q.size() == 0) begin
                  check_val("unexpected_grant", req_ready, 0);
               end else begin
                  cur      = exp_q.pop_front();
                  active   = 1'b1;
                  pump_cnt = 0;
                  since    = 0;
                  check_val("grant_panel", req_ready, 1 << cur.panel);
                  check_val("valve_sel", valve_sel, cur.panel);
                  check_val("disp_cleared", dispensed_ml, 0);
               end
            end else if (active) begin
               since++;
            end
            if (pump_on) begin
               if (!active) begin
                  check_val("pump_when_idle", 1, 0);
               end else begin
                  check_val("progress", dispensed_ml, pump_cnt / CPM);
                  check_val("pump_valve", valve_sel, cur.panel);
                  pump_cnt++;
               end
            end
            if ((done | aborted) != 2'b00) begin
               if (!active) begin
                  check_val("unexpected_end", 1, 0);
               end else begin
                  check_val("end_done", done, (cur.kind == 0) ? (1 << cur.panel) : 0);
                  check_val("end_abort", aborted, (cur.kind == 1) ? (1 << cur.panel) : 0);
                  check_val("final_ml", dispensed_ml, cur.disp);
                  check_val("pump_cycles", pump_cnt, cur.pump);
                  check_val("end_timing", since, (cur.kind == 0) ? pump_cnt + 1 : pump_cnt);
                  active = 1'b0;
                  closed++;
               end
            end
            prev_ready = req_ready;
         end
      end
   end

   initial begin : driver
      logic [1:0] got;
      int n;
      reset        = 1'b0;
      req_valid    = 2'b00;
      req_amount_0 = '0;
      req_amount_1 = '0;
      cancel       = 2'b00;

      #2;
      check_val("rst_pump", pump_on, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_ready", req_ready, 0);
      check_val("rst_done", done, 0);
      check_val("rst_abort", aborted, 0);
      check_val("rst_disp", dispensed_ml, 0);
      check_val("rst_valve", valve_sel, 0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;

      // Basic job on panel 0, then measure the idle gap.
      push_job(0, 0, 3, 6);
      run_single(0, 3);
      wait_end();
      n = 0;
      while (busy && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      check_val("gap_len", n, GAP);

      // Zero-amount job on panel 1.
      push_job(1, 0, 0, 0);
      run_single(1, 0);
      wait_idle();

      // Two rounds of simultaneous requests: round-robin 0 then 1.
      for (int r = 0; r < 2; r++) begin
         req_amount_0 = AW'(2);
         req_amount_1 = AW'(1);
         push_job(0, 0, 2, 4);
         push_job(1, 0, 1, 2);
         req_valid = 2'b11;
         wait_ready(got);
         req_valid = req_valid & ~got;
         wait_ready(got);
         req_valid = req_valid & ~got;
         wait_idle();
         check_val("valve_hold", valve_sel, 1);
      end

      // Cancel after 3 pump cycles; foreign cancel and a withdrawn request are ignored.
      push_job(0, 1, 1, 3);
      run_single(0, 4);
      @(posedge clock); #1;
      cancel       = 2'b10;
      req_amount_1 = AW'(7);
      req_valid    = 2'b10;
      @(posedge clock); #1;
      cancel    = 2'b01;
      req_valid = 2'b00;
      @(posedge clock); #1;
      cancel = 2'b00;
      wait_idle();

      // Cancel on the same edge as the final-ml tick: aborted with incremented count.
      push_job(0, 1, 2, 4);
      run_single(0, 2);
      repeat (3) begin
         @(posedge clock); #1;
      end
      cancel = 2'b01;
      @(posedge clock); #1;
      cancel = 2'b00;
      wait_idle();

      // Clamp above MAX_ML.
      push_job(0, 0, MAXML, MAXML * CPM);
      run_single(0, 12000);
      wait_idle();

      // Reset mid-pump with requests pending; pointer must restart at panel 0.
      push_job(0, 0, 4, 8);
      run_single(0, 4);
      req_amount_1 = AW'(1);
      req_valid    = 2'b11;
      repeat (2) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check_val("arst_pump", pump_on, 0);
      check_val("arst_busy", busy, 0);
      check_val("arst_disp", dispensed_ml, 0);
      push_job(0, 0, 4, 8);
      push_job(1, 0, 1, 2);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      wait_ready(got);
      req_valid = req_valid & ~got;
      wait_ready(got);
      req_valid = req_valid & ~got;
      wait_idle();
      repeat (3) @(posedge clock);
      #1;

      check_val("jobs_closed", closed, 11);
      check_val("queue_empty", exp_q.size(), 0);
      check_val("none_active", active, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
